// File: rtl/light_stand_mode_ctrl_if.sv
// Button-pulse inputs and lamp/status outputs of the light stand sequencer.
// The master side drives the buttons; the slave side is the controller.
interface light_stand_mode_ctrl_if;
   logic       i_btn_power;
   logic       i_btn_mode;
   logic       i_btn_timer;
   logic       o_light;
   logic [1:0] o_mode;
   logic       o_timer_active;

   modport master (
      output i_btn_power, i_btn_mode, i_btn_timer,
      input  o_light, o_mode, o_timer_active
   );

   modport slave (
      input  i_btn_power, i_btn_mode, i_btn_timer,
      output o_light, o_mode, o_timer_active
   );
endinterface

// File: rtl/light_stand_mode_ctrl.sv
// Light stand sequencer: brightness-mode FSM, auto-off countdown and
// glitch-free PWM lamp drive with period-aligned duty changes.
module light_stand_mode_ctrl #(
   parameter int PWM_PERIOD  = 100,
   parameter int DUTY_LOW    = 20,
   parameter int DUTY_MID    = 50,
   parameter int DUTY_HIGH   = 100,
   parameter int TIMER_TICKS = 3_000_000
) (
   input  logic                    i_clk,
   input  logic                    i_reset_n,
   light_stand_mode_ctrl_if.slave  bus
);
   localparam int PW = (PWM_PERIOD > 2) ? $clog2(PWM_PERIOD) : 1;
   localparam int DW = $clog2(PWM_PERIOD + 1);
   localparam int TW = $clog2(TIMER_TICKS + 1);

   typedef enum logic [1:0] {
      ST_OFF  = 2'b00,
      ST_LOW  = 2'b01,
      ST_MID  = 2'b10,
      ST_HIGH = 2'b11
   } state_t;

   state_t          r_state;
   logic            r_timer_active;
   logic [TW-1:0]   r_timer_cnt;
   logic [PW-1:0]   r_pwm_cnt;
   logic [DW-1:0]   r_duty;
   logic            r_light;

   state_t          w_state_nxt;
   logic            w_timer_active_nxt;
   logic [TW-1:0]   w_timer_cnt_nxt;
   logic [PW-1:0]   w_pwm_nxt;
   logic [DW-1:0]   w_duty_nxt;
   logic [DW-1:0]   w_state_duty;
   logic            w_light_nxt;
   logic            w_expire;
   logic            w_wrap;
   logic            w_enter_off;

   // State, countdown, PWM counter, duty latch and lamp registers
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state        <= ST_OFF;
         r_timer_active <= 1'b0;
         r_timer_cnt    <= {TW{1'b0}};
         r_pwm_cnt      <= {PW{1'b0}};
         r_duty         <= {DW{1'b0}};
         r_light        <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_timer_active <= w_timer_active_nxt;
         r_timer_cnt    <= w_timer_cnt_nxt;
         r_pwm_cnt      <= w_pwm_nxt;
         r_duty         <= w_duty_nxt;
         r_light        <= w_light_nxt;
      end
   end

   // Mode FSM and auto-off countdown; expiry and power outrank timer and mode
   always_comb begin
      w_state_nxt        = r_state;
      w_timer_active_nxt = r_timer_active;
      w_timer_cnt_nxt    = r_timer_cnt;
      w_expire           = r_timer_active && (r_timer_cnt == TW'(1));
      if (w_expire || bus.i_btn_power) begin
         if (r_state == ST_OFF) begin
            w_state_nxt = ST_LOW;
         end else begin
            w_state_nxt = ST_OFF;
         end
         w_timer_active_nxt = 1'b0;
         w_timer_cnt_nxt    = {TW{1'b0}};
      end else if (r_state != ST_OFF) begin
         if (bus.i_btn_timer) begin
            if (r_timer_active) begin
               w_timer_active_nxt = 1'b0;
               w_timer_cnt_nxt    = {TW{1'b0}};
            end else begin
               w_timer_active_nxt = 1'b1;
               w_timer_cnt_nxt    = TW'(TIMER_TICKS);
            end
         end else if (r_timer_active) begin
            w_timer_cnt_nxt = r_timer_cnt - TW'(1);
         end else begin
            w_timer_cnt_nxt = r_timer_cnt;
         end
         if (bus.i_btn_mode) begin
            case (r_state)
               ST_LOW:  w_state_nxt = ST_MID;
               ST_MID:  w_state_nxt = ST_HIGH;
               ST_HIGH: w_state_nxt = ST_LOW;
               default: w_state_nxt = ST_OFF;
            endcase
         end else begin
            w_state_nxt = r_state;
         end
      end else begin
         w_state_nxt = r_state;
      end
   end

   // PWM counter, duty latch (period-aligned, immediate zero on entering OFF) and lamp level
   always_comb begin
      w_wrap      = (r_pwm_cnt == PW'(PWM_PERIOD - 1));
      w_enter_off = (r_state != ST_OFF) && (w_state_nxt == ST_OFF);
      case (r_state)
         ST_LOW:  w_state_duty = DW'(DUTY_LOW);
         ST_MID:  w_state_duty = DW'(DUTY_MID);
         ST_HIGH: w_state_duty = DW'(DUTY_HIGH);
         default: w_state_duty = {DW{1'b0}};
      endcase
      if (w_wrap) begin
         w_pwm_nxt = {PW{1'b0}};
      end else begin
         w_pwm_nxt = r_pwm_cnt + PW'(1);
      end
      if (w_enter_off) begin
         w_duty_nxt = {DW{1'b0}};
      end else if (w_wrap) begin
         w_duty_nxt = w_state_duty;
      end else begin
         w_duty_nxt = r_duty;
      end
      w_light_nxt = (DW'(w_pwm_nxt) < w_duty_nxt);
   end

   assign bus.o_mode         = r_state;
   assign bus.o_timer_active = r_timer_active;
   assign bus.o_light        = r_light;
endmodule
